// File: rtl/inverter_stim_monitor.sv
// rtl/inverter_stim_monitor.sv - square-wave stimulus and per-edge delay/error monitor around the inverter macro
// Optional INV_STIM_STOP_ON_ERR_EN: first timeout or glitch halts the run once stim_out is back low.
module inverter_stim_monitor #(
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             clr_stats,
    input  logic [DIV_W-1:0] half_period,
    input  logic             resp_in,
    output logic             stim_out,
    output logic             busy,
    output logic [CNT_W-1:0] delay_last,
    output logic [CNT_W-1:0] err_cnt,
    output logic             timeout_flag
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RESP = 2'd1, WAIT_HALF = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stim_q, stim_d;
    logic [DIV_W-1:0]       phase_q, phase_d;
    logic [DIV_W-1:0]       hp_q, hp_d;
    logic [CNT_W-1:0]       dly_q, dly_d;
    logic [CNT_W-1:0]       delay_q, delay_d;
    logic [CNT_W-1:0]       err_q, err_d;
    logic                   tmo_q, tmo_d;
    logic                   glitch_q, glitch_d;

    logic             rs, resp_ok, boundary, do_toggle;
    logic             timeout_evt, glitch_evt, err_evt, stop_req, go_req;
    logic [CNT_W-1:0] dly_inc;
    logic [DIV_W-1:0] h_eff;

    // dly_q lags the edge count by one, so a match seen through rs reports the edge rs itself changed.
    assign rs          = sync_q[SYNC_STAGES-1];
    assign resp_ok     = (rs == ~stim_q);
    assign boundary    = ({1'b0, phase_q} + (DIV_W+1)'(1)) == {1'b0, hp_q};
    assign h_eff       = (half_period == '0) ? DIV_W'(1) : half_period;
    assign dly_inc     = (dly_q == '1) ? dly_q : dly_q + CNT_W'(1);
    assign timeout_evt = ena && (state_q == WAIT_RESP) && boundary && !resp_ok;
    assign glitch_evt  = ena && (state_q == WAIT_HALF) && !resp_ok && !glitch_q;
    assign err_evt     = timeout_evt || glitch_evt;

`ifdef INV_STIM_STOP_ON_ERR_EN
    logic halt_q, halt_d;

    always_comb begin
        halt_d = halt_q;
        if (!start)    halt_d = 1'b0;
        if (err_evt)   halt_d = 1'b1;
        if (clr_stats) halt_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else        halt_q <= halt_d;
    end

    assign stop_req = !start || halt_q || err_evt;
    assign go_req   = start && !halt_q;
`else
    assign stop_req = !start;
    assign go_req   = start;
`endif

    always_comb begin
        state_d   = state_q;
        stim_d    = stim_q;
        phase_d   = phase_q + DIV_W'(1);
        hp_d      = hp_q;
        dly_d     = dly_inc;
        delay_d   = delay_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        glitch_d  = glitch_q;
        do_toggle = 1'b0;
        sync_d    = {sync_q[SYNC_STAGES-2:0], resp_in};

        if (!ena) begin
            state_d = IDLE;
            stim_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    stim_d    = 1'b0;
                    do_toggle = go_req;
                end
                WAIT_RESP: begin
                    if (resp_ok) begin
                        delay_d = dly_q;
                        state_d = WAIT_HALF;
                    end else if (boundary) begin
                        delay_d = '1;
                        tmo_d   = 1'b1;
                    end
                end
                WAIT_HALF: begin
                    if (glitch_evt) glitch_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            // Stop only from the low phase so every run has an even number of toggles.
            if (state_q != IDLE && boundary) begin
                if (stim_q || !stop_req) begin
                    do_toggle = 1'b1;
                end else begin
                    state_d = IDLE;
                    stim_d  = 1'b0;
                end
            end
        end

        if (do_toggle) begin
            stim_d   = ~stim_q;
            phase_d  = '0;
            dly_d    = '0;
            hp_d     = h_eff;
            glitch_d = 1'b0;
            state_d  = WAIT_RESP;
        end

        if (err_evt && err_q != '1) err_d = err_q + CNT_W'(1);

        if (clr_stats) begin
            delay_d = '0;
            err_d   = '0;
            tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= '1;
            stim_q   <= 1'b0;
            phase_q  <= '0;
            hp_q     <= DIV_W'(1);
            dly_q    <= '0;
            delay_q  <= '0;
            err_q    <= '0;
            tmo_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            stim_q   <= stim_d;
            phase_q  <= phase_d;
            hp_q     <= hp_d;
            dly_q    <= dly_d;
            delay_q  <= delay_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            glitch_q <= glitch_d;
        end
    end

    assign stim_out     = stim_q;
    assign busy         = (state_q != IDLE);
    assign delay_last   = delay_q;
    assign err_cnt      = err_q;
    assign timeout_flag = tmo_q;
endmodule

// File: tb/tb_inverter_stim_monitor.sv
// tb/tb_inverter_stim_monitor.sv - self-checking bench for inverter_stim_monitor with a behavioural reference model
module tb_inverter_stim_monitor;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, clr_stats, resp_in;
    logic [7:0] half_period;
    logic       stim_out, busy, timeout_flag;
    logic [7:0] delay_last, err_cnt;

    inverter_stim_monitor #(.DIV_W(8), .CNT_W(8), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .clr_stats(clr_stats),
        .half_period(half_period), .resp_in(resp_in), .stim_out(stim_out), .busy(busy),
        .delay_last(delay_last), .err_cnt(err_cnt), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: run flag, current level, edges since the last toggle, measurement status.
    bit m_run, m_stim, m_await, m_glitched, m_halt, m_tmo;
    int m_since, m_h, m_delay, m_err;
    bit samp[$];
    bit stim_hist[$];

    int resp_mode;
    int resp_dly;
    bit stuck_val;
    bit pulse;

    function automatic logic [18:0] mvec();
        return {m_stim, m_run, 8'(m_delay), 8'(m_err), m_tmo};
    endfunction

    task automatic model_reset();
        m_run = 0; m_stim = 0; m_await = 0; m_glitched = 0; m_halt = 0; m_tmo = 0;
        m_since = 0; m_h = 1; m_delay = 0; m_err = 0;
        samp = {};
        for (int i = 0; i < SYNC; i++) samp.push_back(1'b1);
        stim_hist = {};
        for (int i = 0; i < 16; i++) stim_hist.push_back(1'b0);
    endtask

    task automatic m_toggle();
        m_stim = !m_stim; m_since = 0; m_await = 1; m_glitched = 0; m_run = 1;
        m_h = (half_period == 8'd0) ? 1 : int'(half_period);
    endtask

    task automatic model_edge();
        bit rs, err_evt, bnd, halt_stop;
        if (!rst_n) begin model_reset(); return; end
        rs = samp[SYNC-1];
        err_evt = 0;
        halt_stop = 0;
        if (!ena) begin
            m_run = 0; m_stim = 0;
        end else if (!m_run) begin
            if (start && !m_halt) m_toggle();
        end else begin
            m_since++;
            bnd = (m_since == m_h);
            if (m_await) begin
                if (rs != m_stim) begin
                    m_delay = (m_since - 1 > 255) ? 255 : m_since - 1;
                    m_await = 0;
                end else if (bnd) begin
                    m_delay = 255; m_tmo = 1; err_evt = 1;
                end
            end else if (rs == m_stim && !m_glitched) begin
                m_glitched = 1; err_evt = 1;
            end
`ifdef INV_STIM_STOP_ON_ERR_EN
            halt_stop = m_halt || err_evt;
`endif
            if (bnd) begin
                if (!m_stim && (!start || halt_stop)) m_run = 0;
                else m_toggle();
            end
        end
        if (err_evt && m_err < 255) m_err++;
`ifdef INV_STIM_STOP_ON_ERR_EN
        if (!start) m_halt = 0;
        if (err_evt) m_halt = 1;
        if (clr_stats) m_halt = 0;
`endif
        if (clr_stats) begin m_delay = 0; m_err = 0; m_tmo = 0; end
        samp.push_front(resp_in); void'(samp.pop_back());
        stim_hist.push_front(m_stim); void'(stim_hist.pop_back());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (resp_mode == 0) resp_in = ~stim_hist[resp_dly] ^ pulse;
        else resp_in = stuck_val ^ pulse;
    endtask

    task automatic drain();
        start = 0;
        for (int i = 0; i < 600; i++) begin
            if (!m_run && !busy) break;
            cycle();
        end
        cycle();
    endtask

    task automatic clear_stats();
        clr_stats = 1; cycle(); clr_stats = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; ena = 0; start = 0; clr_stats = 0; half_period = 8'd10;
        resp_mode = 0; resp_dly = 0; stuck_val = 1; pulse = 0; resp_in = 1;
        model_reset();
        repeat (2) cycle();
        n_cmp++; if (stim_out !== 1'b0) begin n_fail++; $display("FAIL reset_stim got=%b exp=0", stim_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (delay_last !== 8'd0) begin n_fail++; $display("FAIL reset_delay got=%0d exp=0", delay_last); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        n_cmp++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL reset_tmo got=%b exp=0", timeout_flag); end
        rst_n = 1; ena = 1;
        repeat (3) cycle();
    endtask

    task automatic test_loopback();
        int rise_prev, period;
        bit prev;
        rise_prev = -1; period = 0; prev = 0;
        resp_mode = 0; resp_dly = 0; half_period = 8'd10; start = 1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            n_cmp++;
            if ({stim_out, busy, delay_last, err_cnt, timeout_flag} !== mvec()) begin
                n_fail++; $display("FAIL loopback_cyc%0d got=%h exp=%h", i, {stim_out, busy, delay_last, err_cnt, timeout_flag}, mvec());
            end
            if (stim_out && !prev) begin
                if (rise_prev >= 0) period = i - rise_prev;
                rise_prev = i;
            end
            prev = stim_out;
        end
        drain();
        n_cmp++; if (period != 20) begin n_fail++; $display("FAIL loopback_period got=%0d exp=20", period); end
        n_cmp++; if (delay_last !== 8'd2) begin n_fail++; $display("FAIL loopback_delay got=%0d exp=2", delay_last); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL loopback_err got=%0d exp=0", err_cnt); end
        n_cmp++; if ({busy, stim_out} !== 2'b00) begin n_fail++; $display("FAIL loopback_stop got=%b exp=00", {busy, stim_out}); end
    endtask

    task automatic test_delay5();
        clear_stats();
        resp_mode = 0; resp_dly = 5; half_period = 8'd10; start = 1;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            n_cmp++;
            if ({stim_out, busy, delay_last, err_cnt, timeout_flag} !== mvec()) begin
                n_fail++; $display("FAIL delay5_cyc%0d got=%h exp=%h", i, {stim_out, busy, delay_last, err_cnt, timeout_flag}, mvec());
            end
        end
        drain();
        n_cmp++; if (delay_last !== 8'd7) begin n_fail++; $display("FAIL delay5_delay got=%0d exp=7", delay_last); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL delay5_err got=%0d exp=0", err_cnt); end
        n_cmp++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL delay5_tmo got=%b exp=0", timeout_flag); end
        resp_dly = 0;
    endtask

    task automatic test_stuck();
        clear_stats();
        resp_mode = 1; stuck_val = 1; half_period = 8'd6; start = 1;
        for (int i = 1; i <= 43; i++) begin
            cycle();
            n_cmp++;
            if ({stim_out, busy, delay_last, err_cnt, timeout_flag} !== mvec()) begin
                n_fail++; $display("FAIL stuck_cyc%0d got=%h exp=%h", i, {stim_out, busy, delay_last, err_cnt, timeout_flag}, mvec());
            end
        end
`ifdef INV_STIM_STOP_ON_ERR_EN
        n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL stuck_halt_err got=%0d exp=1", err_cnt); end
        n_cmp++; if ({busy, stim_out} !== 2'b00) begin n_fail++; $display("FAIL stuck_halt_idle got=%b exp=00", {busy, stim_out}); end
`else
        n_cmp++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL stuck_err got=%0d exp=4", err_cnt); end
        n_cmp++; if (delay_last !== 8'hFF) begin n_fail++; $display("FAIL stuck_delay got=%h exp=ff", delay_last); end
`endif
        n_cmp++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL stuck_tmo got=%b exp=1", timeout_flag); end
        drain();
        resp_mode = 0;
        repeat (3) cycle();
    endtask

    task automatic test_glitch();
        clear_stats();
        resp_mode = 0; resp_dly = 0; half_period = 8'd6; start = 1;
        for (int e = 1; e <= 8; e++) begin
            pulse = (e == 2 || e == 4);
            cycle();
            n_cmp++;
            if ({stim_out, busy, delay_last, err_cnt, timeout_flag} !== mvec()) begin
                n_fail++; $display("FAIL glitch_cyc%0d got=%h exp=%h", e, {stim_out, busy, delay_last, err_cnt, timeout_flag}, mvec());
            end
        end
        pulse = 0;
        n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL glitch_err got=%0d exp=1", err_cnt); end
        drain();
    endtask

    task automatic test_clr();
        clear_stats();
        resp_mode = 1; stuck_val = 1; half_period = 8'd6; start = 1;
        repeat (6) cycle();
        clr_stats = 1;
        cycle();
        clr_stats = 0;
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_err got=%0d exp=0", err_cnt); end
        n_cmp++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL clr_tmo got=%b exp=0", timeout_flag); end
        n_cmp++; if (delay_last !== 8'd0) begin n_fail++; $display("FAIL clr_delay got=%0d exp=0", delay_last); end
        drain();
        resp_mode = 0;
        repeat (3) cycle();
    endtask

    task automatic test_reset_ena();
        clear_stats();
        half_period = 8'd10; start = 1;
        cycle();
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({stim_out, busy, delay_last, err_cnt, timeout_flag} !== 19'd0) begin
            n_fail++; $display("FAIL midrun_reset got=%h exp=0", {stim_out, busy, delay_last, err_cnt, timeout_flag});
        end
        cycle();
        rst_n = 1;
        repeat (5) cycle();
        ena = 0;
        cycle();
        n_cmp++; if ({busy, stim_out} !== 2'b00) begin n_fail++; $display("FAIL ena_idle got=%b exp=00", {busy, stim_out}); end
        n_cmp++; if (delay_last !== 8'd2) begin n_fail++; $display("FAIL ena_hold_delay got=%0d exp=2", delay_last); end
        start = 0;
        cycle();
        ena = 1;
        repeat (3) cycle();
    endtask

    task automatic test_random();
        start = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) start = ~start;
            if ($urandom_range(0, 19) == 0) half_period = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 39) == 0) resp_dly = $urandom_range(0, 4);
            if ($urandom_range(0, 59) == 0) begin resp_mode = $urandom_range(0, 1); stuck_val = 1'($urandom_range(0, 1)); end
            pulse = ($urandom_range(0, 24) == 0);
            clr_stats = ($urandom_range(0, 49) == 0);
            ena = ($urandom_range(0, 99) != 0);
            cycle();
            n_cmp++;
            if ({stim_out, busy, delay_last, err_cnt, timeout_flag} !== mvec()) begin
                n_fail++; $display("FAIL random_cyc%0d got=%h exp=%h", i, {stim_out, busy, delay_last, err_cnt, timeout_flag}, mvec());
            end
        end
        pulse = 0; clr_stats = 0; ena = 1;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_delay5();
        test_stuck();
        test_glitch();
        test_clr();
        test_reset_ena();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
